fifo_wr_rd_sched: RTL and testbench
===================================

Name: fifo_wr_rd_sched

Overview:
- Shares the single-port synchronous FIFO (4-bit data, 16 deep, one `en` pin) between N write requesters and one read consumer.
- The FIFO's `en` pin selects write (1) or read (0, drains if not empty), so write and read are mutually exclusive each cycle. This block decides every cycle.
- Round-robin grant among writers.
- Write-burst limit guarantees the consumer a read slot.
- Returns read data with a valid strobe.
- Sits between producer agents and the FIFO instance; drives FIFO en/data_in, observes full/empty/data_out.

Parameters:
- N_REQ, 4, number of write requesters (2..8)
- DW, 4, data width; must match FIFO width
- MAX_WR_BURST, 4, consecutive write cycles allowed while rd_req pending and FIFO not empty (1..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  write request per requester, level; held until granted
- wdata  in  N_REQ*DW  requester data, slice i = wdata[i*DW +: DW]
- gnt  out  N_REQ  one-hot write grant; data of granted slice written at this edge
- fifo_en  out  1  to FIFO en: 1 = write, 0 = read/idle
- fifo_din  out  DW  to FIFO data_in
- fifo_full  in  1  from FIFO full
- fifo_empty  in  1  from FIFO empty
- fifo_dout  in  DW  from FIFO data_out (registered in FIFO)
- rd_req  in  1  consumer wants data; affects priority only
- rd_valid  out  1  rd_data holds a newly read word this cycle
- rd_data  out  DW  read word

Behaviour:
- Reset (async, while rst=1):
  - gnt=0, fifo_en=0, fifo_din=0, rd_valid=0, rd_data=0, rr_ptr=0, burst_cnt=0, state=S_IDLE.
  - gnt/fifo_en forced 0 combinationally during rst.
- Grant (combinational, same cycle):
  - Candidate set = req, masked to 0 if fifo_full=1 or read slot forced.
  - Winner = first set bit at or above rr_ptr, wrapping modulo N_REQ.
  - gnt = one-hot winner; fifo_en = |gnt; fifo_din = wdata slice of winner, else 0.
- rr_ptr:
  - On a granted edge, rr_ptr <= (winner+1) mod N_REQ.
  - Otherwise unchanged.
- Read slot forced when rd_req=1 && fifo_empty=0 && burst_cnt==MAX_WR_BURST.
- burst_cnt:
  - +1 on each write edge, saturating at MAX_WR_BURST.
  - Cleared to 0 on any edge with fifo_en=0.
- Read detection: FIFO reads on any edge with fifo_en=0 && fifo_empty=0.
  - At that edge, rd_valid <= 1; otherwise rd_valid <= 0.
  - rd_data = fifo_dout while rd_valid=1; holds last value otherwise.
  - Latency: 1 cycle from the read edge.
- Unsolicited reads: idle cycles drain the FIFO even if rd_req=0, and rd_valid still pulses. The consumer must accept every pulse; there is no backpressure.
- FSM (registered, describes last edge):
  - S_IDLE: no write, FIFO empty.
  - S_WR: write granted.
  - S_RD: read performed.
  - Next state = S_WR if fifo_en, else S_RD if !fifo_empty, else S_IDLE.
  - State is exported only for debug/assertions.
- Boundaries:
  - full=1 and all req=1: no gnt; FIFO reads; burst_cnt cleared.
  - empty=1 and rd_req=1: forced slot never taken; writes proceed.
  - Single requester: granted every cycle subject to full/burst limit.
  - rst mid-burst: all state cleared; a pending rd_valid is dropped.
  - rr_ptr pointing at a non-requesting index: search wraps.

Optional Feature:
- Macro FIFO_SCHED_STATS_EN.
- Defined:
  - Adds outputs wr_cnt[15:0] and rd_cnt[15:0], counting write edges and read edges (rd_valid pulses).
  - Adds starve_flag, a sticky bit set when any req stays high 2*N_REQ*MAX_WR_BURST cycles without grant.
  - All three are cleared by rst; counters wrap.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package fifo_sched_pkg:
  - state enum sched_state_t {S_IDLE, S_WR, S_RD}
  - default DW=4, FIFO_DEPTH=16, STARVE_MULT=2
- Sub-module rr_arbiter: request vector + pointer in, one-hot grant + winner index out; purely combinational.
- Pointer register stays in fifo_sched_wr_rd.

Test Plan:
1. rst pulse mid-cycle with req=4'b1111 -> gnt=0, fifo_en=0, rd_valid=0 immediately; after release, first gnt=4'b0001.
2. req=4'b1011 held, rd_req=0, FIFO empty -> gnt sequence 0001, 0010, 1000, 0001; fifo_din follows the matching slice.
3. req=4'b0001 held, rd_req=1, MAX_WR_BURST=4 -> four writes, then one cycle fifo_en=0; rd_valid=1 the next cycle with the first written word; then writes resume.
4. Fill 16 words, req held -> gnt=0 while full; FIFO drains one word; next cycle gnt resumes; rd_valid pulse observed.
5. All req=0, FIFO holding 3, 5, 7 -> rd_valid on three consecutive cycles with rd_data 3, 5, 7, then rd_valid=0 and state S_IDLE.
6. With FIFO_SCHED_STATS_EN, case 3 run for 20 cycles -> wr_cnt=16, rd_cnt=4, starve_flag=0.

Source files
------------

// File: rtl/fifo_sched_pkg.sv
// rtl/fifo_sched_pkg.sv - shared types and defaults for the FIFO write/read scheduler
//
// Purpose: scheduler state encoding and default sizing used by fifo_wr_rd_sched
//          and its round-robin arbiter.
// Contents:
//   sched_state_t  S_IDLE / S_WR / S_RD, what happened at the last clock edge
//   DEF_DW         default FIFO data width
//   FIFO_DEPTH     depth of the shared FIFO instance
//   STARVE_MULT    starvation window = STARVE_MULT * N_REQ * MAX_WR_BURST cycles

package fifo_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } sched_state_t;

    localparam int DEF_DW      = 4;
    localparam int FIFO_DEPTH  = 16;
    localparam int STARVE_MULT = 2;

endpackage

// File: rtl/fifo_wr_rd_sched_rr_arbiter.sv
// rtl/fifo_wr_rd_sched_rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: picks the first set request at or above ptr, wrapping to index 0.
// Ports:
//   req     in  N   request vector (already masked by the caller)
//   ptr     in  PW  search start index, always < N
//   gnt     out N   one-hot grant, zero when no request
//   winner  out PW  index of the granted request, zero when no request
//   any     out 1   a grant was issued

module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] winner,
    output logic          any
);

    // Two passes instead of a modulo index: the first pass only looks at
    // indices >= ptr, the second falls back to the lowest set bit, which is
    // exactly the wrap-around case.
    always_comb begin
        gnt    = '0;
        winner = '0;
        any    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                winner = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                winner = PW'(i);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_rd_sched.sv
// rtl/fifo_wr_rd_sched.sv - write/read scheduler for a single-port shared FIFO
//
// Purpose: every cycle decides whether the shared FIFO writes (one of N_REQ
//          round-robin requesters) or reads (drains a word to the consumer).
//          A write-burst limit forces a read slot while rd_req is pending.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req[N_REQ]          level write requests, held until granted
//   wdata[N_REQ*DW]     requester data, slice i = wdata[i*DW +: DW]
//   gnt[N_REQ]          one-hot write grant, word written at this edge
//   fifo_en             FIFO en: 1 = write, 0 = read (or idle when empty)
//   fifo_din            FIFO data_in
//   fifo_full/empty     FIFO status
//   fifo_dout           FIFO data_out (registered inside the FIFO)
//   rd_req              consumer wants data, raises read priority only
//   rd_valid, rd_data   read word strobe and data, one cycle after a read edge
// Optional (macro FIFO_SCHED_STATS_EN):
//   wr_cnt, rd_cnt      wrapping counts of write and read edges
//   starve_flag         sticky, a request waited a full starvation window

module fifo_wr_rd_sched
    import fifo_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DW           = DEF_DW,
    parameter int MAX_WR_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic                fifo_en,
    output logic [DW-1:0]       fifo_din,
    input  logic                fifo_full,
    input  logic                fifo_empty,
    input  logic [DW-1:0]       fifo_dout,
    input  logic                rd_req,
    output logic                rd_valid,
    output logic [DW-1:0]       rd_data
`ifdef FIFO_SCHED_STATS_EN
    ,
    output logic [15:0]         wr_cnt,
    output logic [15:0]         rd_cnt,
    output logic                starve_flag
`endif
);

    localparam int         PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [3:0] BURST_MAX = 4'(MAX_WR_BURST);

    sched_state_t      state;
    sched_state_t      next_state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     ptr_next;
    logic [PW-1:0]     winner;
    logic [N_REQ-1:0]  cand;
    logic [N_REQ-1:0]  arb_gnt;
    logic              arb_any;
    logic [3:0]        burst_cnt;
    logic              force_rd;
    logic              rd_fire;
    logic [DW-1:0]     rd_hold;

    // The consumer only gets a guaranteed slot when there is something to read;
    // with an empty FIFO the writers keep going regardless of rd_req.
    assign force_rd = rd_req && !fifo_empty && (burst_cnt == BURST_MAX);

    // Masking with rst keeps gnt/fifo_en low for the whole reset pulse, not
    // just from the next edge.
    assign cand = (rst || fifo_full || force_rd) ? '0 : req;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_arb (
        .req    (cand),
        .ptr    (rr_ptr),
        .gnt    (arb_gnt),
        .winner (winner),
        .any    (arb_any)
    );

    assign ptr_next = (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);

    // Any edge without a write is a read if the FIFO has data, including
    // cycles nobody asked for: the consumer must take every pulse.
    assign rd_fire = !fifo_en && !fifo_empty;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM: next state, describing what this edge does
    always_comb begin
        next_state = S_IDLE;
        if (fifo_en) begin
            next_state = S_WR;
        end else if (!fifo_empty) begin
            next_state = S_RD;
        end
    end

    // FSM: outputs toward the FIFO, decided in the same cycle
    always_comb begin
        gnt      = arb_gnt;
        fifo_en  = arb_any;
        fifo_din = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                fifo_din = wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            burst_cnt <= '0;
            rd_valid  <= 1'b0;
            rd_hold   <= '0;
        end else begin
            if (fifo_en) begin
                rr_ptr <= ptr_next;
                if (burst_cnt != BURST_MAX) begin
                    burst_cnt <= burst_cnt + 4'd1;
                end
            end else begin
                burst_cnt <= '0;
            end
            rd_valid <= rd_fire;
            if (rd_valid) begin
                rd_hold <= fifo_dout;
            end
        end
    end

    // fifo_dout is already registered in the FIFO, so it is presented
    // directly while valid and latched afterwards to hold the last word.
    assign rd_data = rd_valid ? fifo_dout : rd_hold;

    // A write at the previous edge always leaves at least one word behind.
    a_wr_not_empty : assert property (@(posedge clk) disable iff (rst)
        (state == S_WR) |-> !fifo_empty);

`ifdef FIFO_SCHED_STATS_EN
    localparam int         STARVE_LIMIT = STARVE_MULT * N_REQ * MAX_WR_BURST;
    localparam logic [7:0] STARVE_LAST  = 8'(STARVE_LIMIT - 1);

    logic [7:0] wait_cnt [N_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            starve_flag <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            if (fifo_en) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && !gnt[i]) begin
                    if (wait_cnt[i] != STARVE_LAST) begin
                        wait_cnt[i] <= wait_cnt[i] + 8'd1;
                    end else begin
                        starve_flag <= 1'b1;
                    end
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_rd_sched.sv
// tb/tb_fifo_wr_rd_sched.sv - directed scoreboard bench for fifo_wr_rd_sched with a 16-deep FIFO model

module tb_fifo_wr_rd_sched;
    import fifo_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] wdata;
    logic [3:0]  gnt;
    logic        fifo_en;
    logic [3:0]  fifo_din;
    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  fifo_dout;
    logic        rd_req;
    logic        rd_valid;
    logic [3:0]  rd_data;
`ifdef FIFO_SCHED_STATS_EN
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;
    logic        starve_flag;
`endif

    int         total = 0;
    int         bad   = 0;
    logic [3:0] sb [$];
    logic [3:0] mon_exp;
    logic [3:0] v;

    always #5 clk = ~clk;

    fifo_wr_rd_sched #(
        .N_REQ        (4),
        .DW           (4),
        .MAX_WR_BURST (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .wdata       (wdata),
        .gnt         (gnt),
        .fifo_en     (fifo_en),
        .fifo_din    (fifo_din),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .rd_req      (rd_req),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data)
`ifdef FIFO_SCHED_STATS_EN
        ,
        .wr_cnt      (wr_cnt),
        .rd_cnt      (rd_cnt),
        .starve_flag (starve_flag)
`endif
    );

    // Single-port FIFO model: en=1 writes if not full, en=0 reads if not empty.
    logic [3:0] mem [16];
    logic [3:0] wp;
    logic [3:0] rp;
    logic [4:0] cnt;

    assign fifo_full  = (cnt == 5'd16);
    assign fifo_empty = (cnt == 5'd0);

    always @(posedge clk) begin
        if (!rst && fifo_en && !fifo_full) mem[wp] <= fifo_din;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= 4'd0; rp <= 4'd0; cnt <= 5'd0; fifo_dout <= 4'd0;
        end else if (fifo_en && !fifo_full) begin
            wp <= wp + 4'd1; cnt <= cnt + 5'd1;
        end else if (!fifo_en && !fifo_empty) begin
            fifo_dout <= mem[rp]; rp <= rp + 4'd1; cnt <= cnt - 5'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [3:0] din_of(input logic [3:0] g);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 0; k < 4; k++) if (g[k]) r = wdata[k*4 +: 4];
        return r;
    endfunction

    task automatic set_w(input logic [3:0] s0, input logic [3:0] s1,
                         input logic [3:0] s2, input logic [3:0] s3);
        wdata = {s3, s2, s1, s0};
    endtask

    // Called just after inputs are driven at a falling edge; checks the
    // same-cycle grant, records the expected written word, then waits a cycle.
    task automatic expect_cycle(input logic [3:0] eg, input string tag);
        #1;
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".en"},  32'(fifo_en), 32'(|eg));
        chk({tag, ".din"}, 32'(fifo_din), 32'(din_of(eg)));
        if (|eg) sb.push_back(din_of(eg));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req = 4'd0;
        for (int i = 0; i < n; i++) expect_cycle(4'd0, "idle");
    endtask

    // Scoreboard: every rd_valid pulse must match the oldest written word.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $error("FAIL sb_underflow observed=%0h expected=none", rd_data);
            end else begin
                mon_exp = sb.pop_front();
                chk("sb.rd_data", 32'(rd_data), 32'(mon_exp));
            end
        end
    end

    initial begin
        rst = 1'b1; req = 4'd0; wdata = 16'd0; rd_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.gnt",      32'(gnt), 32'd0);
        chk("rst.en",       32'(fifo_en), 32'd0);
        chk("rst.din",      32'(fifo_din), 32'd0);
        chk("rst.rd_valid", 32'(rd_valid), 32'd0);
        chk("rst.rd_data",  32'(rd_data), 32'd0);
        chk("rst.state",    32'(dut.state), 32'(S_IDLE));

        // Reset masks grants combinationally; a mid-cycle reset drops rd_valid.
        req = 4'b1111; set_w(4'h1, 4'h2, 4'h3, 4'h4);
        #1;
        chk("t1.gnt_in_rst", 32'(gnt), 32'd0);
        chk("t1.en_in_rst",  32'(fifo_en), 32'd0);
        rst = 1'b0;
        expect_cycle(4'b0001, "t1.first");
        req = 4'd0;
        expect_cycle(4'b0000, "t1.read");
        chk("t1.rd_valid_pending", 32'(rd_valid), 32'd1);
        req = 4'b1111;
        #2 rst = 1'b1;
        #1;
        chk("t1.gnt_midrst",   32'(gnt), 32'd0);
        chk("t1.en_midrst",    32'(fifo_en), 32'd0);
        chk("t1.rdv_midrst",   32'(rd_valid), 32'd0);
        chk("t1.rdata_midrst", 32'(rd_data), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;

        // Round robin over 1011 starting from pointer 0.
        req = 4'b1011; set_w(4'h1, 4'h2, 4'hE, 4'h4);
        expect_cycle(4'b0001, "t2.g0");
        expect_cycle(4'b0010, "t2.g1");
        expect_cycle(4'b1000, "t2.g2");
        expect_cycle(4'b0001, "t2.g3");
        idle(6);

        // Pointer sits at 1 with only requester 0 active: search wraps.
        req = 4'b0001;
        set_w(4'h3, 4'h0, 4'h0, 4'h0); expect_cycle(4'b0001, "t5.w3");
        set_w(4'h5, 4'h0, 4'h0, 4'h0); expect_cycle(4'b0001, "t5.w5");
        set_w(4'h7, 4'h0, 4'h0, 4'h0); expect_cycle(4'b0001, "t5.w7");
        req = 4'd0;
        expect_cycle(4'd0, "t5.r0");
        chk("t5.rdv0", 32'(rd_valid), 32'd1); chk("t5.rd0", 32'(rd_data), 32'h3);
        expect_cycle(4'd0, "t5.r1");
        chk("t5.rdv1", 32'(rd_valid), 32'd1); chk("t5.rd1", 32'(rd_data), 32'h5);
        expect_cycle(4'd0, "t5.r2");
        chk("t5.rdv2", 32'(rd_valid), 32'd1); chk("t5.rd2", 32'(rd_data), 32'h7);
        chk("t5.state_rd", 32'(dut.state), 32'(S_RD));
        expect_cycle(4'd0, "t5.r3");
        chk("t5.rdv3", 32'(rd_valid), 32'd0);
        chk("t5.rd_hold", 32'(rd_data), 32'h7);
        chk("t5.state_idle", 32'(dut.state), 32'(S_IDLE));

        // Burst limit: four writes, one forced read slot, writes resume.
        req = 4'b0001; rd_req = 1'b1; v = 4'h8;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) begin
                expect_cycle(4'd0, "t3.forced");
                chk("t3.rdv", 32'(rd_valid), 32'd1);
                chk("t3.rd",  32'(rd_data), (i == 4) ? 32'h8 : 32'h9);
            end else begin
                set_w(v, 4'h0, 4'h0, 4'h0); v = v + 4'd1;
                expect_cycle(4'b0001, "t3.wr");
            end
        end
        rd_req = 1'b0;
        idle(8);

        // Fill to full with all four requesting; grants stop, one read, resume.
        rst = 1'b1; #1 rst = 1'b0;
        sb.delete();
        req = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            set_w(4'(i), 4'(i + 1), 4'(i + 2), 4'(i + 3));
            expect_cycle(4'(1 << (i % 4)), "t4.fill");
        end
        set_w(4'h0, 4'h1, 4'h2, 4'h3);
        expect_cycle(4'd0, "t4.full");
        chk("t4.rdv", 32'(rd_valid), 32'd1);
        chk("t4.rd",  32'(rd_data), 32'h0);
        expect_cycle(4'b0001, "t4.resume");
        idle(18);

`ifdef FIFO_SCHED_STATS_EN
        rst = 1'b1; #1 rst = 1'b0;
        sb.delete();
        chk("t6.wr_cnt0", 32'(wr_cnt), 32'd0);
        chk("t6.rd_cnt0", 32'(rd_cnt), 32'd0);
        req = 4'b0001; rd_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_w(4'(i), 4'h0, 4'h0, 4'h0);
            expect_cycle((i % 5 == 4) ? 4'd0 : 4'b0001, "t6.burst");
        end
        chk("t6.wr_cnt", 32'(wr_cnt), 32'd16);
        chk("t6.rd_cnt", 32'(rd_cnt), 32'd4);
        chk("t6.starve", 32'(starve_flag), 32'd0);
        rd_req = 1'b0;
        idle(14);
`endif

        chk("end.sb_empty", 32'(sb.size()), 32'd0);
        chk("end.state",    32'(dut.state), 32'(S_IDLE));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
